rca_repair_ctrl: RTL

Built-in self-test and repair controller for the 4-bit fault-tolerant ripple-carry adder with one spare full adder (fa0..fa3 in use, fa4 spare). On `start` it takes the adder into test mode and applies a vector sequence on `at`/`bt`/`cint`. It checks each full adder's `adder_sums`/`adder_carrys` against a golden model and builds a per-adder fault mask. It then drives the `is`/`cs`/`ss` steering word that routes around a single faulty adder, or flags the array unrepairable.

---
 rtl/rca_repair_ctrl_if.sv | 34 +++
 rtl/rca_repair_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rca_repair_ctrl_if.sv
// Bundle of every signal between the repair controller and its environment:
// the start/status handshake, the test stimulus driven into the adder array,
// the per-adder observations coming back, and the steering word.
// master = controller side, slave = environment (adder array + requester).

interface rca_repair_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       repaired;
    logic       fail;
    logic [3:0] fault_mask;
    logic       test;
    logic [3:0] at;
    logic [3:0] bt;
    logic       cint;
    logic [3:0] adder_sums;
    logic [3:0] adder_carrys;
    logic [2:0] is;
    logic [4:0] cs;
    logic [3:0] ss;

    modport master (
        input  start, adder_sums, adder_carrys,
        output busy, done, repaired, fail, fault_mask,
               test, at, bt, cint, is, cs, ss
    );

    modport slave (
        output start, adder_sums, adder_carrys,
        input  busy, done, repaired, fail, fault_mask,
               test, at, bt, cint, is, cs, ss
    );
endinterface

// File: rtl/rca_repair_ctrl.sv
// rca_repair_ctrl: built-in self-test and repair controller for the 4-bit
// ripple-carry adder with one spare full adder (fa0..fa3 active, fa4 spare).
// A run walks a vector sequence through the array in test mode, flags each
// adder whose sum/carry disagrees with the golden full-adder function of its
// own observed inputs, then steers around a single faulty adder or reports
// the array unrepairable.
//
// Build option: define RCA_REPAIR_EXHAUSTIVE_EN for the exhaustive 512-vector
// sequence ({cint, bt, at} = k). Without it, an 8-vector sequence is used
// that broadcasts k[0] on at, k[1] on bt and k[2] on cint.

module rca_repair_ctrl (
    input  logic              clk,
    input  logic              rst,
    rca_repair_ctrl_if.master bus
);

`ifdef RCA_REPAIR_EXHAUSTIVE_EN
    localparam int CW = 9;
`else
    localparam int CW = 3;
`endif

    // Both vector counts are powers of two, so the last index is all ones.
    localparam logic [CW-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] vec_cnt_inc;
    logic [8:0]    next_vec;
    logic [3:0]    carry_in;
    logic [3:0]    exp_sum;
    logic [3:0]    exp_carry;
    logic [3:0]    mismatch;
    logic [2:0]    fault_count;
    logic [3:0]    at_or_above;
    logic [2:0]    eval_is;
    logic [4:0]    eval_cs;
    logic [3:0]    eval_ss;
    logic          eval_repaired;
    logic          eval_fail;

    // Maps a vector index to {cint, bt, at}.
    function automatic logic [8:0] vector_of(input logic [CW-1:0] k);
`ifdef RCA_REPAIR_EXHAUSTIVE_EN
        return k;
`else
        return {k[2], {4{k[1]}}, {4{k[0]}}};
`endif
    endfunction

    assign vec_cnt_inc = vec_cnt + 1'b1;
    assign next_vec    = vector_of(vec_cnt_inc);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured when not busy.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (bus.start) state_next = RUN;
            RUN:        if (vec_cnt == LAST_VEC) state_next = EVAL;
            EVAL:       state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Golden check of every adder against its own observed carry-in, so a
    // faulty upstream carry never blames a healthy downstream adder.
    always_comb begin
        carry_in  = {bus.adder_carrys[2:0], bus.cint};
        exp_sum   = bus.at ^ bus.bt ^ carry_in;
        exp_carry = (bus.at & bus.bt) | (bus.at & carry_in) | (bus.bt & carry_in);
        mismatch  = (bus.adder_sums ^ exp_sum) | (bus.adder_carrys ^ exp_carry);
    end

    // Steering word from the final mask; with a single faulty adder j every
    // position from j upward shifts one adder up towards the spare.
    always_comb begin
        fault_count   = '0;
        at_or_above   = '0;
        eval_is       = 3'b000;
        eval_cs       = 5'b10000;
        eval_ss       = 4'b0000;
        eval_repaired = 1'b0;
        eval_fail     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fault_count = fault_count + {2'b00, bus.fault_mask[i]};
        end
        at_or_above[0] = bus.fault_mask[0];
        for (int i = 1; i < 4; i++) begin
            at_or_above[i] = at_or_above[i-1] | bus.fault_mask[i];
        end
        if (fault_count == 3'd1) begin
            eval_is       = at_or_above[2:0];
            eval_cs       = {1'b0, bus.fault_mask};
            eval_ss       = at_or_above;
            eval_repaired = 1'b1;
        end else if (fault_count >= 3'd2) begin
            eval_fail     = 1'b1;
        end
    end

    // Registered outputs, vector counter and fault mask accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt        <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.repaired   <= 1'b0;
            bus.fail       <= 1'b0;
            bus.fault_mask <= 4'b0000;
            bus.test       <= 1'b0;
            bus.at         <= 4'b0000;
            bus.bt         <= 4'b0000;
            bus.cint       <= 1'b0;
            bus.is         <= 3'b000;
            bus.cs         <= 5'b10000;
            bus.ss         <= 4'b0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        vec_cnt                      <= '0;
                        bus.busy                     <= 1'b1;
                        bus.done                     <= 1'b0;
                        bus.repaired                 <= 1'b0;
                        bus.fail                     <= 1'b0;
                        bus.fault_mask               <= 4'b0000;
                        bus.test                     <= 1'b1;
                        {bus.cint, bus.bt, bus.at}   <= vector_of('0);
                        bus.is                       <= 3'b000;
                        bus.cs                       <= 5'b10000;
                        bus.ss                       <= 4'b0000;
                    end
                end
                RUN: begin
                    bus.fault_mask <= bus.fault_mask | mismatch;
                    if (vec_cnt == LAST_VEC) begin
                        bus.test <= 1'b0;
                        bus.at   <= 4'b0000;
                        bus.bt   <= 4'b0000;
                        bus.cint <= 1'b0;
                    end else begin
                        vec_cnt                    <= vec_cnt_inc;
                        {bus.cint, bus.bt, bus.at} <= next_vec;
                    end
                end
                EVAL: begin
                    bus.is       <= eval_is;
                    bus.cs       <= eval_cs;
                    bus.ss       <= eval_ss;
                    bus.repaired <= eval_repaired;
                    bus.fail     <= eval_fail;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                end
                default: begin
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
